// File: rtl/fb_scanout_pkg.sv
// Shared definitions for the framebuffer scanout path: pixel-per-word and frame size
// arithmetic, counter width helper and the line/frame marker bundle.
package fb_scanout_pkg;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
  } marks_t;

  function automatic int calc_ppw(input int data_width, input int pixel_width);
    return data_width / pixel_width;
  endfunction

  function automatic int calc_frame_words(input int line_words, input int lines);
    return line_words * lines;
  endfunction

  // Counters for a range of one still need a single bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel stream leaving the scanout block: valid/ready handshake with line and frame markers.
interface fb_scanout_if #(
  parameter int PIXEL_WIDTH = 1
) ();

  logic                   out_valid;
  logic                   out_ready;
  logic [PIXEL_WIDTH-1:0] out_pixel;
  logic                   out_sol;
  logic                   out_eol;
  logic                   out_sof;

  modport master (
    output out_valid, out_pixel, out_sol, out_eol, out_sof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pixel, out_sol, out_eol, out_sof,
    output out_ready
  );

endinterface

// File: rtl/fb_word_fifo.sv
// Two-entry show-ahead word FIFO; the head word is always visible on dout and a push
// and pop may happen on the same edge.
module fb_word_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && ((count != 2'd2) || pop);
  assign do_pop  = pop && (count != 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone says which entries hold data.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer read side: walks the RAM in raster order, prefetches words to hide the
// registered read latency and unpacks them LSB-first into a marked pixel stream.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int PIXEL_WIDTH = 1,
  parameter int LINE_WORDS  = 16,
  parameter int LINES       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_restart,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  fb_scanout_if.master          px
);

  localparam int PPW         = calc_ppw(DATA_WIDTH, PIXEL_WIDTH);
  localparam int FRAME_WORDS = calc_frame_words(LINE_WORDS, LINES);
  localparam int PIX_W       = cnt_width(PPW);
  localparam int COL_W       = cnt_width(LINE_WORDS);
  localparam bit SINGLE      = (PPW == 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [PIX_W-1:0]      LAST_PIX  = PIX_W'(PPW - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(LINE_WORDS - 1);

  logic                   in_flight;
  logic [1:0]             fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_dout;
  logic                   fifo_pop;
  logic [2:0]             backlog;
  logic                   issue;
  logic                   advance;
  logic                   more_pix;

  logic                   valid_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  marks_t                 marks;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [PIX_W-1:0]       pix;
  logic [ADDR_WIDTH-1:0]  next_word;
  logic [COL_W-1:0]       next_col;
  logic                   last_col_word;

  fb_word_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_restart),
    .push  (in_flight),
    .din   (rd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign advance  = !valid_q || px.out_ready;
  assign more_pix = valid_q && (pix != LAST_PIX);
  assign fifo_pop = advance && !more_pix && (fifo_count != 2'd0);

  // Words buffered or on their way, after this edge's pop, must leave room for one more.
  assign backlog = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, fifo_pop};
  assign issue   = enable && !frame_restart && (backlog < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      in_flight <= 1'b0;
    end else if (frame_restart) begin
      rd_addr   <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) rd_addr <= (rd_addr == LAST_WORD) ? '0 : rd_addr + 1'b1;
    end
  end

  // next_word/next_col describe the FIFO head word, i.e. the next word to be unpacked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      pixel_q       <= '0;
      marks         <= '0;
      shreg         <= '0;
      pix           <= '0;
      next_word     <= '0;
      next_col      <= '0;
      last_col_word <= 1'b0;
    end else if (frame_restart) begin
      valid_q       <= 1'b0;
      pixel_q       <= '0;
      marks         <= '0;
      shreg         <= '0;
      pix           <= '0;
      next_word     <= '0;
      next_col      <= '0;
      last_col_word <= 1'b0;
    end else if (advance) begin
      if (more_pix) begin
        pixel_q <= shreg[PIXEL_WIDTH-1:0];
        shreg   <= shreg >> PIXEL_WIDTH;
        pix     <= pix + 1'b1;
        marks   <= '{sol: 1'b0,
                     eol: last_col_word && ((pix + 1'b1) == LAST_PIX),
                     sof: 1'b0};
      end else if (fifo_count != 2'd0) begin
        valid_q       <= 1'b1;
        pixel_q       <= fifo_dout[PIXEL_WIDTH-1:0];
        shreg         <= fifo_dout >> PIXEL_WIDTH;
        pix           <= '0;
        marks         <= '{sol: (next_col == '0),
                           eol: SINGLE && (next_col == LAST_COL),
                           sof: (next_word == '0)};
        last_col_word <= (next_col == LAST_COL);
        next_col      <= (next_col == LAST_COL) ? '0 : next_col + 1'b1;
        next_word     <= (next_word == LAST_WORD) ? '0 : next_word + 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign px.out_valid = valid_q;
  assign px.out_pixel = pixel_q;
  assign px.out_sol   = marks.sol;
  assign px.out_eol   = marks.eol;
  assign px.out_sof   = marks.sof;

endmodule
